debouncer_multi: RTL and testbench
==================================

# debouncer_multi

Parametrised multi-channel switch debouncer: next generation of the single-channel debouncer, extended to `NumCh` independent channels. Each channel has:
- an on-chip 2-flop synchroniser;
- a stability timer set in microseconds;
- separate rise and fall tick outputs;
- an optional long-press (hold) detector.

It sits between raw board switches/buttons and control logic, replacing per-button debouncer instances.

## Interface
- `NumCh`, 4: number of independent channels (1..32).
- `ClkFreq`, 100_000_000: clock frequency in Hz.
- `StableTimeUs`, 1000: time an input must stay unchanged before it is accepted. `StableCycles = ClkFreq*StableTimeUs/1_000_000`, computed in 64-bit integer arithmetic. Elaboration fails if `StableCycles < 1`.
- `HoldTimeUs`, 0: long-press time measured from the accepted rise. `HoldCycles = ClkFreq*HoldTimeUs/1_000_000`. A value of 0 disables hold detection: `db_hold_o` is tied to 0 and no hold counter is built.
- `clk_i` input, 1 bit: single clock, all logic on its rising edge.
- `rst_i` input, 1 bit: reset, synchronous and active-high.
- `sw_i` input, `NumCh` bits: raw asynchronous switch inputs, bit n = channel n.
- `db_level_o` output, `NumCh` bits: debounced level per channel.
- `db_rise_o` output, `NumCh` bits: one-cycle pulse when `db_level_o[n]` goes 0->1.
- `db_fall_o` output, `NumCh` bits: one-cycle pulse when `db_level_o[n]` goes 1->0.
- `db_hold_o` output, `NumCh` bits: one-cycle pulse once per press, after the level has been 1 for `HoldCycles`.

## Operation
- **Synchroniser.** Per channel, `sync1 <= sw_i[n]`, then `sync2 <= sync1`. Both reset to 0. All decisions use `sync2`.
- **Stability counter.** Per channel, `cnt` is `$clog2(StableCycles+1)` bits wide.
  - If `sync2 == level`: `cnt <= 0`.
  - Otherwise, if `cnt == StableCycles-1`: `level <= sync2`, `cnt <= 0`, and the matching rise or fall pulse fires.
  - Otherwise: `cnt <= cnt+1`.
- **Bounce.** Any return of `sync2` to the current level before acceptance clears `cnt`. Partial progress is never kept.
- **Per-channel FSM** (hold path, only when `HoldTimeUs > 0`). States:
  - LOW: `level = 0`.
  - PRESSED: `level = 1`, `hcnt` counting.
  - HELD: `level = 1`, hold already reported.
  - Transitions: LOW->PRESSED on accepted rise, with `hcnt <= 0`. PRESSED->HELD when `hcnt == HoldCycles-1`; `db_hold_o[n]` pulses that cycle. PRESSED or HELD -> LOW on accepted fall. HELD stays HELD with no further pulses.
  - `hcnt` is `$clog2(HoldCycles+1)` bits and saturates; it never wraps.
- **Channel independence.** Simultaneous changes on several channels are processed in parallel with no interaction. Several bits of any output may pulse in the same cycle.
- **Pulse exclusivity.** `db_rise_o[n]` and `db_fall_o[n]` are never both 1 in a cycle. `db_hold_o[n]` can never coincide with `db_rise_o[n]` when `HoldCycles >= 1`.
- **Reset.** Synchronous reset in any state, including mid-count, clears every `sync1`, `sync2`, `cnt`, `hcnt` and `level`. The FSM returns to LOW. No pulses are produced by reset itself.
  - If `sw_i[n]` is held high through reset release, `db_level_o[n]` rises normally after the full latency below, with a `db_rise_o[n]` pulse.

## Timing
- **Reset values.** `db_level_o`, `db_rise_o`, `db_fall_o` and `db_hold_o` are all 0 in the cycle after any clock edge with `rst_i = 1`.
- **Accept latency.** Let `sw_i[n]` change before edge E0 and stay stable. Then `db_level_o[n]` changes, and the rise/fall pulse is high, in the cycle following edge `E0 + StableCycles + 1`. That is `StableCycles + 2` edges counting E0.
- **Pulse alignment.** Rise/fall pulses are registered, coincide with the first cycle of the new level, and are exactly one cycle wide.
- **Hold latency.** `db_hold_o[n]` pulses `HoldCycles` cycles after the `db_rise_o[n]` cycle.
- **Bounce rejection.** Any stretch shorter than `StableCycles` consecutive cycles at the synchroniser output produces no change.

## Test plan
Unless stated otherwise, all scenarios use `ClkFreq = 100_000_000`, `StableTimeUs = 1` (so `StableCycles = 100`), `HoldTimeUs = 5` (so `HoldCycles = 500`) and `NumCh = 4`.

- **Reset values.** Assert `rst_i` for 5 cycles with `sw_i = 4'hF` -> all outputs 0 during reset. After release, `db_level_o` becomes `4'hF` exactly 102 edges later, with `db_rise_o = 4'hF` for one cycle.
- **Clean press.** `sw_i[0]` goes 0->1 and is held -> `db_rise_o[0]` pulses once, `db_level_o[0] = 1` at edge 102. After 500 more cycles, `db_hold_o[0]` pulses exactly once and never again while held. Release -> `db_fall_o[0]` pulses at +102, no hold pulse.
- **Bounce rejection.** `sw_i[1]` toggles every 37 cycles for 1000 cycles, then settles at 1 -> no output activity during the toggling. A single rise pulse appears 102 edges after the final toggle.
- **Threshold boundary.** A high glitch of 99 cycles on `sw_i[2]` -> no change. A glitch of exactly 100 cycles -> one rise pulse, then one fall pulse 100 cycles later.
- **Simultaneous channels.** `sw_i[3]` and `sw_i[0]` rise on the same edge while `sw_i[1]` falls -> `db_rise_o = 4'b1001` and `db_fall_o = 4'b0010` in the same cycle.
- **Reset mid-operation.** Assert `rst_i` when `cnt` is 60 on channel 2, and separately during PRESSED at `hcnt` 300 -> everything clears. The full 102-edge latency and the 500-cycle hold time restart from zero. No spurious fall pulse is produced.

Source files
------------

// File: rtl/debouncer_multi_if.sv
// debouncer_multi_if: raw switch inputs and debounced
// level/pulse outputs for all channels.
interface debouncer_multi_if #(
  parameter int NumCh = 4
);
  logic [NumCh-1:0] sw_i;
  logic [NumCh-1:0] db_level_o;
  logic [NumCh-1:0] db_rise_o;
  logic [NumCh-1:0] db_fall_o;
  logic [NumCh-1:0] db_hold_o;

  modport master (
    output sw_i,
    input  db_level_o,
    input  db_rise_o,
    input  db_fall_o,
    input  db_hold_o
  );

  modport slave (
    input  sw_i,
    output db_level_o,
    output db_rise_o,
    output db_fall_o,
    output db_hold_o
  );
endinterface

// File: rtl/debouncer_multi.sv
// debouncer_multi: NumCh independent switch debouncers with
// synchroniser, stability timer, edge ticks and long-press detect.
module debouncer_multi #(
  parameter int NumCh        = 4,
  parameter int ClkFreq      = 100_000_000,
  parameter int StableTimeUs = 1000,
  parameter int HoldTimeUs   = 0
) (
  input logic              clk_i,
  input logic              rst_i,
  debouncer_multi_if.slave bus
);

  localparam longint unsigned StableCycles =
    (64'(ClkFreq) * 64'(StableTimeUs)) / 64'd1_000_000;
  localparam longint unsigned HoldCycles =
    (64'(ClkFreq) * 64'(HoldTimeUs)) / 64'd1_000_000;
  localparam int CntW =
    (StableCycles < 1) ? 1 : $clog2(StableCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(StableCycles - 1);

  if (StableCycles < 1) begin : g_bad_stable
    $error("debouncer_multi: StableCycles must be >= 1");
  end
  if (NumCh < 1 || NumCh > 32) begin : g_bad_nch
    $error("debouncer_multi: NumCh must be 1..32");
  end

  logic [NumCh-1:0] sync1;
  logic [NumCh-1:0] sync2;
  logic [NumCh-1:0] level;
  logic [NumCh-1:0] rise;
  logic [NumCh-1:0] fall;
  logic [NumCh-1:0] acc_rise;
  logic [NumCh-1:0] acc_fall;
  logic [CntW-1:0]  cnt [NumCh];

  // Acceptance strobes: input differs and timer has expired.
  always_comb begin
    acc_rise = '0;
    acc_fall = '0;
    for (int i = 0; i < NumCh; i++) begin
      if (sync2[i] != level[i] && cnt[i] == CntMax) begin
        acc_rise[i] = sync2[i];
        acc_fall[i] = ~sync2[i];
      end
    end
  end

  // Synchroniser, stability timer, level and edge ticks.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      rise  <= '0;
      fall  <= '0;
      for (int i = 0; i < NumCh; i++) cnt[i] <= '0;
    end else begin
      sync1 <= bus.sw_i;
      sync2 <= sync1;
      rise  <= acc_rise;
      fall  <= acc_fall;
      for (int i = 0; i < NumCh; i++) begin
        if (sync2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CntMax) begin
          level[i] <= sync2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + CntW'(1);
        end
      end
    end
  end

  assign bus.db_level_o = level;
  assign bus.db_rise_o  = rise;
  assign bus.db_fall_o  = fall;

  if (HoldCycles > 0) begin : g_hold
    localparam int HoldW = $clog2(HoldCycles + 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(HoldCycles - 1);

    typedef enum logic [1:0] {
      Low,
      Pressed,
      Held
    } hstate_e;

    hstate_e          state [NumCh];
    logic [HoldW-1:0] hcnt  [NumCh];
    logic [NumCh-1:0] hold;

    // Per-channel long-press FSM; a fall always wins.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        hold <= '0;
        for (int i = 0; i < NumCh; i++) begin
          state[i] <= Low;
          hcnt[i]  <= '0;
        end
      end else begin
        hold <= '0;
        for (int i = 0; i < NumCh; i++) begin
          unique case (state[i])
            Low: begin
              if (acc_rise[i]) begin
                state[i] <= Pressed;
                hcnt[i]  <= '0;
              end
            end
            Pressed: begin
              if (acc_fall[i]) begin
                state[i] <= Low;
              end else if (hcnt[i] == HoldMax) begin
                state[i] <= Held;
                hold[i]  <= 1'b1;
              end else if (hcnt[i] != '1) begin
                hcnt[i] <= hcnt[i] + HoldW'(1);
              end
            end
            Held: begin
              if (acc_fall[i]) state[i] <= Low;
            end
            default: state[i] <= Low;
          endcase
        end
      end
    end

    assign bus.db_hold_o = hold;
  end else begin : g_no_hold
    assign bus.db_hold_o = '0;
  end

endmodule

// File: tb/tb_debouncer_multi.sv
// tb_debouncer_multi: scoreboard bench for debouncer_multi,
// 4 channels, 100 stable cycles, 500 hold cycles.
module tb_debouncer_multi;

  typedef struct {
    int         cyc;
    logic [3:0] r;
    logic [3:0] f;
    logic [3:0] h;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edges = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  q[$];

  debouncer_multi_if #(.NumCh(4)) bus ();

  debouncer_multi #(
    .NumCh(4),
    .ClkFreq(100_000_000),
    .StableTimeUs(1),
    .HoldTimeUs(5)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edges++;

  // Scoreboard: every pulse must match the queue head in time and value.
  always @(negedge clk) begin
    ev_t e;
    if (|bus.db_rise_o || |bus.db_fall_o || |bus.db_hold_o) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d rise=%b fall=%b hold=%b, none expected",
                 edges, bus.db_rise_o, bus.db_fall_o, bus.db_hold_o);
      end else begin
        e = q.pop_front();
        if (e.cyc !== edges || e.r !== bus.db_rise_o ||
            e.f !== bus.db_fall_o || e.h !== bus.db_hold_o) begin
          errors++;
          $display("FAIL pulse got cyc=%0d r=%b f=%b h=%b need cyc=%0d r=%b f=%b h=%b",
                   edges, bus.db_rise_o, bus.db_fall_o, bus.db_hold_o,
                   e.cyc, e.r, e.f, e.h);
        end
      end
    end else if (q.size() > 0 && q[0].cyc < edges) begin
      checks++;
      errors++;
      e = q.pop_front();
      $display("FAIL missed_pulse at cyc=%0d got none need r=%b f=%b h=%b",
               e.cyc, e.r, e.f, e.h);
    end
  end

  task automatic push(input int c, input logic [3:0] r,
                      input logic [3:0] f, input logic [3:0] h);
    ev_t e;
    e.cyc = c;
    e.r = r;
    e.f = f;
    e.h = h;
    q.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (edges < c) @(negedge clk);
  endtask

  task automatic drain(output bit ok);
    int n = 0;
    while (q.size() > 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    ok = (q.size() == 0);
  endtask

  task automatic test_reset();
    int t;
    bit ok;
    @(negedge clk);
    rst = 1'b1;
    bus.sw_i = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.db_level_o, bus.db_rise_o, bus.db_fall_o, bus.db_hold_o} !== 16'h0) begin
        errors++;
        $display("FAIL reset_outputs got %h need 0000",
                 {bus.db_level_o, bus.db_rise_o, bus.db_fall_o, bus.db_hold_o});
      end
    end
    rst = 1'b0;
    t = edges;
    push(t + 102, 4'hF, 4'h0, 4'h0);
    push(t + 602, 4'h0, 4'h0, 4'hF);
    wait_to(t + 101);
    checks++;
    if (bus.db_level_o !== 4'h0) begin
      errors++;
      $display("FAIL reset_early_level got %h need 0", bus.db_level_o);
    end
    wait_to(t + 102);
    checks++;
    if (bus.db_level_o !== 4'hF) begin
      errors++;
      $display("FAIL reset_rise_level got %h need f", bus.db_level_o);
    end
    wait_to(t + 700);
    drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reset_drain pending=%0d need 0", q.size());
    end
    @(negedge clk);
    bus.sw_i = 4'h0;
    t = edges;
    push(t + 102, 4'h0, 4'hF, 4'h0);
    wait_to(t + 102);
    checks++;
    if (bus.db_level_o !== 4'h0) begin
      errors++;
      $display("FAIL reset_fall_level got %h need 0", bus.db_level_o);
    end
    drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reset_fall_drain pending=%0d need 0", q.size());
    end
  endtask

  task automatic test_clean_press();
    int t;
    bit ok;
    @(negedge clk);
    bus.sw_i[0] = 1'b1;
    t = edges;
    push(t + 102, 4'h1, 4'h0, 4'h0);
    push(t + 602, 4'h0, 4'h0, 4'h1);
    wait_to(t + 101);
    checks++;
    if (bus.db_level_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL press_early got %b need 0", bus.db_level_o[0]);
    end
    wait_to(t + 102);
    checks++;
    if (bus.db_level_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL press_level got %b need 1", bus.db_level_o[0]);
    end
    wait_to(t + 902);
    drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL press_drain pending=%0d need 0", q.size());
    end
    @(negedge clk);
    bus.sw_i[0] = 1'b0;
    t = edges;
    push(t + 102, 4'h0, 4'h1, 4'h0);
    wait_to(t + 102);
    checks++;
    if (bus.db_level_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL release_level got %b need 0", bus.db_level_o[0]);
    end
    wait_to(t + 300);
    drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL release_drain pending=%0d need 0", q.size());
    end
  endtask

  task automatic test_bounce();
    int t = 0;
    bit ok;
    for (int k = 0; k < 27; k++) begin
      @(negedge clk);
      bus.sw_i[1] = ~bus.sw_i[1];
      t = edges;
      repeat (36) @(negedge clk);
    end
    checks++;
    if (bus.db_level_o[1] !== 1'b0) begin
      errors++;
      $display("FAIL bounce_level got %b need 0", bus.db_level_o[1]);
    end
    push(t + 102, 4'h2, 4'h0, 4'h0);
    push(t + 602, 4'h0, 4'h0, 4'h2);
    wait_to(t + 102);
    checks++;
    if (bus.db_level_o[1] !== 1'b1) begin
      errors++;
      $display("FAIL bounce_settle got %b need 1", bus.db_level_o[1]);
    end
    drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bounce_drain pending=%0d need 0", q.size());
    end
  endtask

  task automatic test_threshold();
    int t;
    bit ok;
    @(negedge clk);
    bus.sw_i[2] = 1'b1;
    repeat (99) @(negedge clk);
    bus.sw_i[2] = 1'b0;
    repeat (200) @(negedge clk);
    checks++;
    if (bus.db_level_o[2] !== 1'b0) begin
      errors++;
      $display("FAIL glitch99_level got %b need 0", bus.db_level_o[2]);
    end
    @(negedge clk);
    bus.sw_i[2] = 1'b1;
    t = edges;
    push(t + 102, 4'h4, 4'h0, 4'h0);
    push(t + 202, 4'h0, 4'h4, 4'h0);
    repeat (100) @(negedge clk);
    bus.sw_i[2] = 1'b0;
    wait_to(t + 102);
    checks++;
    if (bus.db_level_o[2] !== 1'b1) begin
      errors++;
      $display("FAIL glitch100_level got %b need 1", bus.db_level_o[2]);
    end
    wait_to(t + 400);
    drain(ok);
    checks++;
    if (!ok || bus.db_level_o[2] !== 1'b0) begin
      errors++;
      $display("FAIL glitch100_end pending=%0d level=%b need 0/0",
               q.size(), bus.db_level_o[2]);
    end
  endtask

  task automatic test_simultaneous();
    int t;
    bit ok;
    @(negedge clk);
    bus.sw_i = 4'b1001;
    t = edges;
    push(t + 102, 4'b1001, 4'b0010, 4'h0);
    push(t + 602, 4'h0, 4'h0, 4'b1001);
    wait_to(t + 102);
    checks++;
    if (bus.db_level_o !== 4'b1001) begin
      errors++;
      $display("FAIL simul_level got %b need 1001", bus.db_level_o);
    end
    wait_to(t + 650);
    drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL simul_drain pending=%0d need 0", q.size());
    end
    @(negedge clk);
    bus.sw_i = 4'h0;
    t = edges;
    push(t + 102, 4'h0, 4'b1001, 4'h0);
    wait_to(t + 200);
    drain(ok);
    checks++;
    if (!ok || bus.db_level_o !== 4'h0) begin
      errors++;
      $display("FAIL simul_release pending=%0d level=%b need 0/0000",
               q.size(), bus.db_level_o);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    bit ok;
    @(negedge clk);
    bus.sw_i[2] = 1'b1;
    t = edges;
    wait_to(t + 62);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({bus.db_level_o, bus.db_rise_o, bus.db_fall_o, bus.db_hold_o} !== 16'h0) begin
        errors++;
        $display("FAIL midcnt_reset got %h need 0000",
                 {bus.db_level_o, bus.db_rise_o, bus.db_fall_o, bus.db_hold_o});
      end
    end
    rst = 1'b0;
    t = edges;
    push(t + 102, 4'h4, 4'h0, 4'h0);
    wait_to(t + 101);
    checks++;
    if (bus.db_level_o[2] !== 1'b0) begin
      errors++;
      $display("FAIL midcnt_early got %b need 0", bus.db_level_o[2]);
    end
    wait_to(t + 102);
    checks++;
    if (bus.db_level_o[2] !== 1'b1) begin
      errors++;
      $display("FAIL midcnt_level got %b need 1", bus.db_level_o[2]);
    end
    wait_to(t + 402);
    q.delete();
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({bus.db_level_o, bus.db_rise_o, bus.db_fall_o, bus.db_hold_o} !== 16'h0) begin
        errors++;
        $display("FAIL midhold_reset got %h need 0000",
                 {bus.db_level_o, bus.db_rise_o, bus.db_fall_o, bus.db_hold_o});
      end
    end
    rst = 1'b0;
    t = edges;
    push(t + 102, 4'h4, 4'h0, 4'h0);
    push(t + 602, 4'h0, 4'h0, 4'h4);
    wait_to(t + 650);
    drain(ok);
    checks++;
    if (!ok || bus.db_level_o !== 4'h4) begin
      errors++;
      $display("FAIL midhold_restart pending=%0d level=%b need 0/0100",
               q.size(), bus.db_level_o);
    end
    @(negedge clk);
    bus.sw_i[2] = 1'b0;
    t = edges;
    push(t + 102, 4'h0, 4'h4, 4'h0);
    wait_to(t + 200);
    drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midhold_release pending=%0d need 0", q.size());
    end
  endtask

  initial begin
    bus.sw_i = 4'h0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_threshold();
    test_simultaneous();
    test_reset_mid();
    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
